// File: rtl/axil_regbank_if.sv
// AXI4-Lite slave-side bus bundle for axil_regbank.
// Signal names follow the s_axi_* naming of the register bank's bus.
interface axil_regbank_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 6
) ();
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [1:0]              s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [1:0]              s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        output s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
        input  s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_regbank.sv
// AXI4-Lite register bank: byte-strobed writes, per-register write pulses, concurrent reads.
// Define AXIL_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axil_regbank #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 4,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    axil_regbank_if.slave                  s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_stb
);
    localparam int unsigned StrbW   = DATA_WIDTH / 8;
    localparam int unsigned AddrLsb = $clog2(StrbW);
    localparam int unsigned IdxW    = ADDR_WIDTH - AddrLsb;
    localparam logic [1:0]  RespOkay = 2'b00;
`ifdef AXIL_REGBANK_SLVERR_EN
    localparam logic [1:0]  RespOor  = 2'b10;
`else
    localparam logic [1:0]  RespOor  = 2'b00;
`endif

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  aw_full_q, aw_full_d;
    logic [IdxW-1:0]       aw_idx_q, aw_idx_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [StrbW-1:0]      w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IdxW-1:0]       ar_idx;
    logic                  aw_in_range, ar_in_range;
    logic [NUM_REGS-1:0]   wr_sel;
    logic [DATA_WIDTH-1:0] rd_val;

    // Byte-offset bits never select anything.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{s_axi.s_axi_awaddr[AddrLsb-1:0], s_axi.s_axi_araddr[AddrLsb-1:0]};

    assign s_axi.s_axi_awready = !ARESET && !aw_full_q && !bvalid_q;
    assign s_axi.s_axi_wready  = !ARESET && !w_full_q && !bvalid_q;
    assign s_axi.s_axi_arready = !ARESET && !rvalid_q;
    assign s_axi.s_axi_bvalid  = bvalid_q;
    assign s_axi.s_axi_bresp   = bresp_q;
    assign s_axi.s_axi_rvalid  = rvalid_q;
    assign s_axi.s_axi_rdata   = rdata_q;
    assign s_axi.s_axi_rresp   = rresp_q;
    assign wr_stb              = wr_stb_q;

    assign aw_hs  = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
    assign w_hs   = s_axi.s_axi_wvalid && s_axi.s_axi_wready;
    assign ar_hs  = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
    assign commit = aw_full_q && w_full_q;
    assign ar_idx = s_axi.s_axi_araddr[ADDR_WIDTH-1:AddrLsb];

    // Index decode; an index matching no register is out of range and reads as zero.
    always_comb begin
        wr_sel      = '0;
        rd_val      = '0;
        aw_in_range = 1'b0;
        ar_in_range = 1'b0;
        for (int k = 0; k < int'(NUM_REGS); k++) begin
            if (aw_idx_q == IdxW'(k)) begin
                wr_sel[k]   = 1'b1;
                aw_in_range = 1'b1;
            end
            if (ar_idx == IdxW'(k)) begin
                rd_val      = regs_q[k];
                ar_in_range = 1'b1;
            end
        end
    end

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        regs_d    = regs_q;
        wr_stb_d  = commit ? wr_sel : '0;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_in_range ? RespOkay : RespOor;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                for (int b = 0; b < int'(StrbW); b++) begin
                    if (wr_sel[k] && w_strb_q[b]) begin
                        regs_d[k][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end else if (bvalid_q && s_axi.s_axi_bready) begin
            bvalid_d = 1'b0;
        end

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axi.s_axi_awaddr[ADDR_WIDTH-1:AddrLsb];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axi.s_axi_wdata;
            w_strb_d = s_axi.s_axi_wstrb;
        end

        // Capture uses regs_q, so a same-edge commit is not visible to this read.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_val;
            rresp_d  = ar_in_range ? RespOkay : RespOor;
        end else if (rvalid_q && s_axi.s_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q    <= '{default: '0};
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            wr_stb_q  <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            wr_stb_q  <= wr_stb_d;
        end
    end

    for (genvar k = 0; k < int'(NUM_REGS); k++) begin : g_reg_out
        assign reg_q[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
    end
endmodule
